// File: rtl/counter_modulo.sv
// Programmable-modulus up/down counter: free-run, one-shot, ping-pong.
// Optional tick prescaler enabled by COUNTER_MODULO_PRESCALER_EN.
module counter_modulo #(
  parameter int unsigned WORD_WIDTH     = 8,
  parameter int unsigned PRESCALE_WIDTH = 4
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      enable_i,
  input  logic                      load_i,
  input  logic [WORD_WIDTH-1:0]     load_value_i,
  input  logic [WORD_WIDTH-1:0]     modulus_i,
  input  logic                      dir_i,
  input  logic [1:0]                mode_i,
`ifdef COUNTER_MODULO_PRESCALER_EN
  input  logic [PRESCALE_WIDTH-1:0] prescale_i,
`endif
  output logic [WORD_WIDTH-1:0]     count_o,
  output logic                      tc_o,
  output logic                      done_o,
  output logic                      dir_o
);

  localparam logic [WORD_WIDTH-1:0] One = WORD_WIDTH'(1);

  logic [WORD_WIDTH-1:0] count_q, count_d;
  logic                  tc_q, tc_d;
  logic                  done_q, done_d;
  logic                  dir_q, dir_d;

  logic active;
  logic ptick;
  logic tick;
  logic pingpong;
  logic oneshot;
  logic d;
  logic term;

  assign active = enable_i & ~done_q;
  assign tick   = active & ptick;

`ifdef COUNTER_MODULO_PRESCALER_EN
  localparam logic [PRESCALE_WIDTH-1:0] POne =
    PRESCALE_WIDTH'(1);

  logic [PRESCALE_WIDTH-1:0] presc_q, presc_d;

  assign ptick = (presc_q == prescale_i);

  always_comb begin
    presc_d = presc_q;
    if (load_i) begin
      presc_d = '0;
    end else if (active) begin
      presc_d = ptick ? '0 : presc_q + POne;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end
`else
  logic [PRESCALE_WIDTH-1:0] unused_prescale;

  assign unused_prescale = '0;
  assign ptick           = 1'b1;
`endif

  assign pingpong = (mode_i == 2'b10);
  assign oneshot  = (mode_i == 2'b01);

  // Ping-pong keeps its own direction; other modes follow dir_i.
  assign d    = pingpong ? dir_q : dir_i;
  assign term = d ? (count_q == '0) : (count_q >= modulus_i);

  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    done_d  = done_q;
    dir_d   = dir_q;
    if (load_i) begin
      count_d = (load_value_i > modulus_i) ? modulus_i
                                           : load_value_i;
      done_d  = 1'b0;
      dir_d   = dir_i;
    end else if (tick) begin
      dir_d = d;
      if (!term) begin
        count_d = d ? count_q - One : count_q + One;
      end else begin
        tc_d = 1'b1;
        unique case (1'b1)
          pingpong: begin
            dir_d = ~d;
            // Bounce off the limit; a zero modulus pins count at 0.
            if (d) begin
              count_d = (modulus_i == '0) ? '0 : One;
            end else begin
              count_d = (count_q == '0) ? '0 : count_q - One;
            end
          end
          oneshot: begin
            done_d = 1'b1;
          end
          default: begin
            count_d = d ? modulus_i : '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      tc_q    <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      tc_q    <= tc_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign count_o = count_q;
  assign tc_o    = tc_q;
  assign done_o  = done_q;
  assign dir_o   = dir_q;

endmodule

// File: tb/tb_counter_modulo.sv
// Bench for counter_modulo: directed scenarios plus randomized
// stimulus checked every cycle against a behavioural model.
module tb_counter_modulo;

  localparam int W  = 8;
  localparam int PW = 4;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         en    = 1'b0;
  logic         ld    = 1'b0;
  logic         dir   = 1'b0;
  logic [W-1:0] lv    = '0;
  logic [W-1:0] mod   = '0;
  logic [1:0]   mode  = '0;
`ifdef COUNTER_MODULO_PRESCALER_EN
  logic [PW-1:0] psc  = '0;
`endif

  logic [W-1:0] count;
  logic         tc;
  logic         done;
  logic         dir_o;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_on   = 1'b0;

  int m_count = 0, m_tc = 0, m_done = 0, m_dir = 0, m_ps = 0;
  int n_count = 0, n_tc = 0, n_done = 0, n_dir = 0, n_ps = 0;

  int e1[8]  = '{1, 2, 3, 4, 5, 0, 1, 2};
  int e2[8]  = '{5, 4, 3, 2, 1, 0, 6, 5};
  int e3[6]  = '{1, 2, 3, 3, 3, 3};
  int e4c[7] = '{1, 2, 1, 0, 1, 2, 1};
  int e4d[7] = '{0, 0, 1, 1, 0, 0, 1};
  int e4t[7] = '{0, 0, 1, 0, 1, 0, 1};
`ifdef COUNTER_MODULO_PRESCALER_EN
  int e6[9]  = '{0, 0, 1, 1, 1, 2, 2, 2, 3};
`endif

  counter_modulo #(
    .WORD_WIDTH    (W),
    .PRESCALE_WIDTH(PW)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .enable_i    (en),
    .load_i      (ld),
    .load_value_i(lv),
    .modulus_i   (mod),
    .dir_i       (dir),
    .mode_i      (mode),
`ifdef COUNTER_MODULO_PRESCALER_EN
    .prescale_i  (psc),
`endif
    .count_o     (count),
    .tc_o        (tc),
    .done_o      (done),
    .dir_o       (dir_o)
  );

  always #5 clk = ~clk;

  task automatic check(string nm, int act, int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Next state from the behavioural rules, using the inputs
  // that will be sampled at the coming rising edge.
  task automatic model_step();
    int c  = m_count;
    int t  = 0;
    int dn = m_done;
    int dr = m_dir;
    int ps = m_ps;
    int md = int'(mod);
    bit run, pt, d, term;
    run = en && (m_done == 0);
    pt  = 1'b1;
`ifdef COUNTER_MODULO_PRESCALER_EN
    pt = (m_ps == int'(psc));
    if (run) ps = pt ? 0 : (m_ps + 1) % (1 << PW);
`endif
    if (ld) begin
      c  = (int'(lv) > md) ? md : int'(lv);
      dn = 0;
      dr = int'(dir);
      ps = 0;
    end else if (run && pt) begin
      d    = (mode == 2'b10) ? m_dir[0] : dir;
      term = d ? (c == 0) : (c >= md);
      dr   = int'(d);
      if (!term) begin
        c = d ? c - 1 : c + 1;
      end else begin
        t = 1;
        case (mode)
          2'b01: dn = 1;
          2'b10: begin
            dr = int'(!d);
            if (d) c = (md == 0) ? 0 : 1;
            else   c = (c == 0) ? 0 : c - 1;
          end
          default: c = d ? md : 0;
        endcase
      end
    end
    n_count <= c;
    n_tc    <= t;
    n_done  <= dn;
    n_dir   <= dr;
    n_ps    <= ps;
  endtask

  always @(negedge clk) begin
    #1;
    model_step();
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_count <= 0;
      m_tc    <= 0;
      m_done  <= 0;
      m_dir   <= 0;
      m_ps    <= 0;
    end else begin
      m_count <= n_count;
      m_tc    <= n_tc;
      m_done  <= n_done;
      m_dir   <= n_dir;
      m_ps    <= n_ps;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      check("model_count", int'(count), m_count);
      check("model_tc", int'(tc), m_tc);
      check("model_done", int'(done), m_done);
      check("model_dir", int'(dir_o), m_dir);
    end
  end

  initial begin
    repeat (2) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_tc", int'(tc), 0);
    check("rst_done", int'(done), 0);
    check("rst_dir", int'(dir_o), 0);
    chk_on = 1'b1;
    rst_n  = 1'b1;

    mod = 8'd5; dir = 1'b0; mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("fr_count", int'(count), e1[i]);
      check("fr_tc", int'(tc), int'(i == 5));
    end
    en = 1'b0;

    lv = 8'd9; mod = 8'd6; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    check("clamp", int'(count), 6);
    dir = 1'b1; en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("dn_count", int'(count), e2[i]);
      check("dn_tc", int'(tc), int'(i == 6));
    end
    en = 1'b0;

    lv = 8'd0; mod = 8'd3; mode = 2'b01; dir = 1'b0; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("os_count", int'(count), e3[i]);
      check("os_tc", int'(tc), int'(i == 3));
      check("os_done", int'(done), int'(i >= 3));
    end
    en = 1'b0; lv = 8'd1; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0;
    check("os_reload_done", int'(done), 0);
    check("os_reload_count", int'(count), 1);

    lv = 8'd0; mod = 8'd2; mode = 2'b10; dir = 1'b0; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      check("pp_count", int'(count), e4c[i]);
      check("pp_dir", int'(dir_o), e4d[i]);
      check("pp_tc", int'(tc), e4t[i]);
    end
    mod = 8'd0;
    @(negedge clk);
    check("pp0_count", int'(count), 0);
    check("pp0_tc", int'(tc), 0);
    repeat (3) begin
      @(negedge clk);
      check("pp0_count", int'(count), 0);
      check("pp0_tc", int'(tc), 1);
    end
    en = 1'b0;

    mode = 2'b00; mod = 8'd4; lv = 8'd4; ld = 1'b1;
    @(negedge clk);
    en = 1'b1; dir = 1'b0; lv = 8'd2;
    @(negedge clk);
    ld = 1'b0;
    check("prio_count", int'(count), 2);
    check("prio_tc", int'(tc), 0);
    dir = 1'b1;
    @(negedge clk);
    check("pre_rst_dir", int'(dir_o), 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_count", int'(count), 0);
    check("arst_tc", int'(tc), 0);
    check("arst_done", int'(done), 0);
    check("arst_dir", int'(dir_o), 0);
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;

`ifdef COUNTER_MODULO_PRESCALER_EN
    psc = 4'd2; mod = 8'd3; lv = 8'd0; mode = 2'b00; dir = 1'b0;
    ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; en = 1'b1;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      check("ps_count", int'(count), e6[i]);
    end
    en = 1'b0; ld = 1'b1;
    @(negedge clk);
    ld = 1'b0; en = 1'b1;
    @(negedge clk);
    en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    check("ps_gap_hold", int'(count), 0);
    @(negedge clk);
    check("ps_gap_step", int'(count), 1);
    en = 1'b0;
`endif

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      en   = ($urandom_range(0, 9) < 8);
      ld   = ($urandom_range(0, 99) < 8);
      dir  = ($urandom_range(0, 9) < 2) ? ~dir : dir;
      mode = ($urandom_range(0, 29) == 0) ? 2'($urandom) : mode;
      if ($urandom_range(0, 19) == 0)
        mod = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                          : 8'($urandom_range(0, 12));
      lv   = ($urandom_range(0, 3) == 0) ? 8'($urandom)
                                         : 8'($urandom_range(0, 15));
`ifdef COUNTER_MODULO_PRESCALER_EN
      if ($urandom_range(0, 49) == 0) psc = 4'($urandom_range(0, 3));
`endif
      if ($urandom_range(0, 399) == 0) begin
        #2 rst_n = 1'b0;
        #1 check("rnd_arst_count", int'(count), 0);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
